// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared CPU control-word layout used by control, forwarding and ID/EX stage
package id_ex_stage_pkg;
  localparam int CTRL_W        = 9;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_REGDST   = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_BRANCH   = 0;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use compare against the registered ID/EX instruction
module hazard_detect (
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);
  always_comb load_use = mem_read && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and bubble counter
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [4:0]        IF_ID_RegisterRs,
  input  logic [4:0]        IF_ID_RegisterRt,
  input  logic [4:0]        IF_ID_RegisterRd,
  input  logic [DATA_W-1:0] IF_ID_RsData,
  input  logic [DATA_W-1:0] IF_ID_RtData,
  input  logic [DATA_W-1:0] IF_ID_Imm,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic              Flush_i,
  input  logic              MemStall_i,
  output logic [4:0]        ID_EX_RegisterRs,
  output logic [4:0]        ID_EX_RegisterRt,
  output logic [4:0]        ID_EX_RegisterRd,
  output logic [DATA_W-1:0] ID_EX_RsData,
  output logic [DATA_W-1:0] ID_EX_RtData,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic [CTRL_W-1:0] ID_EX_Ctrl,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic [CNT_W-1:0]  BubbleCnt
);
  logic load_use;
  hazard_detect u_hazard (
    .mem_read(ID_EX_Ctrl[CTRL_MEMREAD]),
    .ex_rt   (ID_EX_RegisterRt),
    .id_rs   (IF_ID_RegisterRs),
    .id_rt   (IF_ID_RegisterRt),
    .load_use(load_use)
  );
  always_comb begin
    PCWrite     = !(load_use || MemStall_i);
    IF_ID_Write = PCWrite;
  end
  // Flush takes the bubble slot, so only an unflushed load-use bubble is counted
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ID_EX_Ctrl       <= '0;
      ID_EX_RegisterRs <= '0;
      ID_EX_RegisterRt <= '0;
      ID_EX_RegisterRd <= '0;
      ID_EX_RsData     <= '0;
      ID_EX_RtData     <= '0;
      ID_EX_Imm        <= '0;
      BubbleCnt        <= '0;
    end else if (!MemStall_i) begin
      ID_EX_Ctrl       <= (Flush_i || load_use) ? '0 : ID_Ctrl;
      ID_EX_RegisterRs <= (Flush_i || load_use) ? '0 : IF_ID_RegisterRs;
      ID_EX_RegisterRt <= (Flush_i || load_use) ? '0 : IF_ID_RegisterRt;
      ID_EX_RegisterRd <= (Flush_i || load_use) ? '0 : IF_ID_RegisterRd;
      ID_EX_RsData     <= (Flush_i || load_use) ? '0 : IF_ID_RsData;
      ID_EX_RtData     <= (Flush_i || load_use) ? '0 : IF_ID_RtData;
      ID_EX_Imm        <= (Flush_i || load_use) ? '0 : IF_ID_Imm;
      if (load_use && !Flush_i && !(&BubbleCnt))
        BubbleCnt <= BubbleCnt + CNT_W'(1);
    end
  end
endmodule
